raytrace_frame_scheduler: RTL and testbench

- Sequences the ray-tracing core across one frame: generates pixel coordinates in raster order and issues one ray request per pixel.
- Waits for the core's colour result, guarded by a watchdog, and hands each finished pixel to the output packer through a valid/ready port.
- Sits between the top-level control inputs (start/abort from ui_in) and the trace core / uo_out packer inside tt_um_ieeeuoftasic_raytracer.

---
 rtl/raytrace_frame_scheduler.sv | 154 +++++++++++++++
 tb/tb_raytrace_frame_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raytrace_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : raytrace_frame_scheduler
// Purpose  : Walks one frame in raster order, issuing one ray request per pixel
//            and forwarding each colour result (or a watchdog fill) downstream.
// Revision : 1.0
// ============================================================================
module raytrace_frame_scheduler #(
    parameter int H_RES          = 16,
    parameter int V_RES          = 16,
    parameter int XW             = 4,
    parameter int YW             = 4,
    parameter int COLOR_W        = 6,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic               abort,
    output logic               req_valid,
    input  logic               req_ready,
    output logic [XW-1:0]      req_x,
    output logic [YW-1:0]      req_y,
    input  logic               res_valid,
    input  logic [COLOR_W-1:0] res_color,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COLOR_W-1:0] pix_color,
    output logic [XW-1:0]      pix_x,
    output logic [YW-1:0]      pix_y,
    output logic               pix_last,
    output logic               busy,
    output logic               frame_done,
    output logic               timeout_err
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_EMIT  = 2'd3;

    localparam int             WDW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WDW-1:0] c_WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
    localparam logic [XW-1:0]  c_X_LAST  = XW'(H_RES - 1);
    localparam logic [YW-1:0]  c_Y_LAST  = YW'(V_RES - 1);

    logic [1:0]         state_q, state_d;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic [WDW-1:0]     wd_q, wd_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               timeout_q, timeout_d;
    logic               done_q, done_d;

    logic w_x_last;
    logic w_at_last;

    assign w_x_last  = (x_q == c_X_LAST);
    assign w_at_last = w_x_last && (y_q == c_Y_LAST);

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        wd_d      = wd_q;
        color_d   = color_q;
        timeout_d = timeout_q;
        done_d    = 1'b0;
        // abort outranks every transition, including start and the final handshake
        if (abort) begin
            state_d = c_ST_IDLE;
        end else begin
            case (state_q)
                c_ST_IDLE: begin
                    if (start) begin
                        state_d   = c_ST_ISSUE;
                        x_d       = '0;
                        y_d       = '0;
                        timeout_d = 1'b0;
                    end
                end
                c_ST_ISSUE: begin
                    if (req_ready) begin
                        state_d = c_ST_WAIT;
                        wd_d    = '0;
                    end
                end
                c_ST_WAIT: begin
                    if (res_valid) begin
                        state_d = c_ST_EMIT;
                        color_d = res_color;
                    end else if (wd_q == c_WD_LAST) begin
                        state_d   = c_ST_EMIT;
                        color_d   = '0;
                        timeout_d = 1'b1;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
                c_ST_EMIT: begin
                    if (pix_ready) begin
                        if (w_at_last) begin
                            state_d = c_ST_IDLE;
                            done_d  = 1'b1;
                        end else if (w_x_last) begin
                            state_d = c_ST_ISSUE;
                            x_d     = '0;
                            y_d     = y_q + 1'b1;
                        end else begin
                            state_d = c_ST_ISSUE;
                            x_d     = x_q + 1'b1;
                        end
                    end
                end
                default: state_d = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= c_ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            wd_q      <= '0;
            color_q   <= '0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (ena) begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            wd_q      <= wd_d;
            color_q   <= color_d;
            timeout_q <= timeout_d;
            done_q    <= done_d;
        end
    end

    assign req_valid   = (state_q == c_ST_ISSUE);
    assign req_x       = x_q;
    assign req_y       = y_q;
    assign pix_valid   = (state_q == c_ST_EMIT);
    assign pix_color   = color_q;
    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign pix_last    = pix_valid && w_at_last;
    assign busy        = (state_q != c_ST_IDLE);
    assign frame_done  = done_q;
    assign timeout_err = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_raytrace_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_raytrace_frame_scheduler
// Purpose  : Directed and randomized frames for a 2x2 scheduler, timeout 4.
// Revision : 1.0
// ============================================================================
module tb_raytrace_frame_scheduler;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       req_valid;
    logic       req_ready = 1'b0;
    logic [1:0] req_x;
    logic [1:0] req_y;
    logic       res_valid = 1'b0;
    logic [5:0] res_color = '0;
    logic       pix_valid;
    logic       pix_ready = 1'b0;
    logic [5:0] pix_color;
    logic [1:0] pix_x;
    logic [1:0] pix_y;
    logic       pix_last;
    logic       busy;
    logic       frame_done;
    logic       timeout_err;

    int errors = 0;
    int checks = 0;

    raytrace_frame_scheduler #(
        .H_RES(2), .V_RES(2), .XW(2), .YW(2), .COLOR_W(6), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .abort(abort),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
        .res_valid(res_valid), .res_color(res_color),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_color(pix_color),
        .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last),
        .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic serve_pixel(input logic [5:0] c);
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        res_valid = 1'b1; res_color = c; tick(); res_valid = 1'b0;
        pix_ready = 1'b1; tick(); pix_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [19:0] outs;
        tick(); tick();
        outs = {req_valid, req_x, req_y, pix_valid, pix_color, pix_x, pix_y,
                pix_last, busy, frame_done, timeout_err};
        checks++;
        if (outs !== 20'd0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", outs);
        end
        rst_n = 1'b1;
        tick();
        outs = {req_valid, req_x, req_y, pix_valid, pix_color, pix_x, pix_y,
                pix_last, busy, frame_done, timeout_err};
        checks++;
        if (outs !== 20'd0) begin
            errors++; $display("FAIL idle_after_reset: got %h want 0", outs);
        end
    endtask

    // mode 0: spec colours, no stalls; mode 1: backpressure on (1,0) and timeout
    // on (0,1); otherwise random latency, colour and stalls.
    task automatic test_frame(input int mode);
        int lat[4];
        int rrd[4];
        int prd[4];
        logic [5:0] col[4];
        logic [5:0] exp_col;
        logic [1:0] ex, ey;
        bit exp_to;
        int cnt, wait_exp;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: col[i] = 6'h11;
                1: col[i] = 6'h22;
                2: col[i] = 6'h33;
                default: col[i] = 6'h2A;
            endcase
            lat[i] = 0; rrd[i] = 0; prd[i] = 0;
            if (mode == 1) begin
                if (i == 1) prd[i] = 5;
                if (i == 2) lat[i] = 99;
            end else if (mode >= 2) begin
                lat[i] = $urandom_range(0, 6);
                rrd[i] = $urandom_range(0, 2);
                prd[i] = $urandom_range(0, 2);
                col[i] = 6'($urandom);
            end
        end
        start = 1'b1; tick(); start = 1'b0;
        exp_to = 1'b0;
        checks++;
        if ({busy, timeout_err} !== 2'b10) begin
            errors++; $display("FAIL start_frame: busy,timeout got %b want 10", {busy, timeout_err});
        end
        for (int p = 0; p < 4; p++) begin
            ex = 2'(p % 2);
            ey = 2'(p / 2);
            checks++;
            if ({req_valid, req_x, req_y} !== {1'b1, ex, ey}) begin
                errors++; $display("FAIL req_coord: got %h want %h", {req_valid, req_x, req_y}, {1'b1, ex, ey});
            end
            for (int r = 0; r < rrd[p]; r++) begin
                tick();
                checks++;
                if ({req_valid, req_x, req_y} !== {1'b1, ex, ey}) begin
                    errors++; $display("FAIL req_hold: got %h want %h", {req_valid, req_x, req_y}, {1'b1, ex, ey});
                end
            end
            req_ready = 1'b1; tick(); req_ready = 1'b0;
            cnt = 0;
            wait_exp = ((lat[p] < T) ? lat[p] : T - 1) + 1;
            while (1) begin
                if (cnt == lat[p]) begin
                    res_valid = 1'b1; res_color = col[p];
                end
                tick();
                res_valid = 1'b0;
                cnt++;
                if (pix_valid || cnt > 20) break;
            end
            exp_col = (lat[p] < T) ? col[p] : 6'd0;
            if (lat[p] >= T) exp_to = 1'b1;
            checks++;
            if (cnt !== wait_exp) begin
                errors++; $display("FAIL emit_latency: got %0d want %0d", cnt, wait_exp);
            end
            checks++;
            if ({pix_valid, pix_x, pix_y, pix_color, pix_last, timeout_err, req_valid}
                !== {1'b1, ex, ey, exp_col, (p == 3), exp_to, 1'b0}) begin
                errors++;
                $display("FAIL pixel_out: got %h want %h",
                         {pix_valid, pix_x, pix_y, pix_color, pix_last, timeout_err, req_valid},
                         {1'b1, ex, ey, exp_col, (p == 3), exp_to, 1'b0});
            end
            if (lat[p] >= T) begin
                res_valid = 1'b1; res_color = 6'h3F;
            end
            for (int d = 0; d < prd[p]; d++) begin
                tick();
                res_valid = 1'b0;
                checks++;
                if ({pix_valid, pix_x, pix_y, pix_color, req_valid} !== {1'b1, ex, ey, exp_col, 1'b0}) begin
                    errors++;
                    $display("FAIL pixel_stall: got %h want %h",
                             {pix_valid, pix_x, pix_y, pix_color, req_valid}, {1'b1, ex, ey, exp_col, 1'b0});
                end
            end
            pix_ready = 1'b1; tick(); pix_ready = 1'b0; res_valid = 1'b0;
            checks++;
            if ({frame_done, req_valid, pix_valid} !== {(p == 3), (p != 3), 1'b0}) begin
                errors++;
                $display("FAIL after_accept: done,req,pix got %b want %b",
                         {frame_done, req_valid, pix_valid}, {(p == 3), (p != 3), 1'b0});
            end
        end
        tick();
        checks++;
        if ({frame_done, busy, timeout_err} !== {1'b0, 1'b0, exp_to}) begin
            errors++;
            $display("FAIL frame_end: done,busy,timeout got %b want %b",
                     {frame_done, busy, timeout_err}, {1'b0, 1'b0, exp_to});
        end
    endtask

    task automatic test_start_busy_and_async_reset();
        logic [19:0] outs;
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky_idle: got %b want 1", timeout_err);
        end
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("FAIL start_clears_timeout: got %b want 0", timeout_err);
        end
        serve_pixel(6'h05);
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if ({req_valid, req_x, req_y, busy} !== {1'b1, 2'd1, 2'd0, 1'b1}) begin
            errors++; $display("FAIL start_while_busy: got %h want %h", {req_valid, req_x, req_y, busy}, {1'b1, 2'd1, 2'd0, 1'b1});
        end
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        repeat (T) tick();
        checks++;
        if ({pix_valid, pix_x, pix_color, timeout_err} !== {1'b1, 2'd1, 6'd0, 1'b1}) begin
            errors++; $display("FAIL timeout_pixel: got %h want %h", {pix_valid, pix_x, pix_color, timeout_err}, {1'b1, 2'd1, 6'd0, 1'b1});
        end
        #2 rst_n = 1'b0;
        #1;
        outs = {req_valid, req_x, req_y, pix_valid, pix_color, pix_x, pix_y,
                pix_last, busy, frame_done, timeout_err};
        checks++;
        if (outs !== 20'd0) begin
            errors++; $display("FAIL async_reset: got %h want 0", outs);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({busy, req_valid} !== 2'b00) begin
            errors++; $display("FAIL post_reset_idle: got %b want 00", {busy, req_valid});
        end
    endtask

    task automatic test_abort();
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        checks++;
        if ({busy, req_valid} !== 2'b00) begin
            errors++; $display("FAIL abort_beats_start: got %b want 00", {busy, req_valid});
        end
        start = 1'b1; tick(); start = 1'b0;
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        repeat (T) tick();
        pix_ready = 1'b1; tick(); pix_ready = 1'b0;
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        tick();
        abort = 1'b1; tick(); abort = 1'b0;
        checks++;
        if ({busy, req_valid, pix_valid, frame_done, timeout_err} !== 5'b00001) begin
            errors++; $display("FAIL abort_in_wait: got %b want 00001", {busy, req_valid, pix_valid, frame_done, timeout_err});
        end
        res_valid = 1'b1; res_color = 6'h3F; tick(); res_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({pix_valid, frame_done, busy} !== 3'b000) begin
                errors++; $display("FAIL late_result_ignored: got %b want 000", {pix_valid, frame_done, busy});
            end
            tick();
        end
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if ({req_valid, req_x, req_y, timeout_err} !== {1'b1, 2'd0, 2'd0, 1'b0}) begin
            errors++; $display("FAIL restart_origin: got %h want %h", {req_valid, req_x, req_y, timeout_err}, {1'b1, 2'd0, 2'd0, 1'b0});
        end
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic test_ena();
        start = 1'b1; tick(); start = 1'b0;
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        res_valid = 1'b1; res_color = 6'h15; tick(); res_valid = 1'b0;
        pix_ready = 1'b1; ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({pix_valid, pix_color, pix_x, pix_y, req_valid, frame_done} !== {1'b1, 6'h15, 2'd0, 2'd0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL ena_freeze: got %h want %h",
                         {pix_valid, pix_color, pix_x, pix_y, req_valid, frame_done},
                         {1'b1, 6'h15, 2'd0, 2'd0, 1'b0, 1'b0});
            end
        end
        ena = 1'b1; tick(); pix_ready = 1'b0;
        checks++;
        if ({pix_valid, req_valid, req_x, req_y} !== {1'b0, 1'b1, 2'd1, 2'd0}) begin
            errors++; $display("FAIL ena_resume: got %h want %h", {pix_valid, req_valid, req_x, req_y}, {1'b0, 1'b1, 2'd1, 2'd0});
        end
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 10; f++) test_frame(2);
    endtask

    initial begin
        #1;
        test_reset();
        test_frame(0);
        test_frame(1);
        test_start_busy_and_async_reset();
        test_abort();
        test_ena();
        test_random_frames();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
